// File: rtl/instr_mem_loadable.sv
// Byte-addressed instruction memory with a serial byte-load port
// and a registered, range-checked 32-bit fetch port.
module instr_mem_loadable #(
    parameter int DEPTH_BYTES = 128,
    parameter bit BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic [31:0] load_count,
    output logic        load_overflow,
    output logic        busy,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_err
);

    localparam int          AW       = $clog2(DEPTH_BYTES);
    localparam logic [31:0] DEPTH    = 32'(DEPTH_BYTES);
    localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [DEPTH_BYTES];
    logic          enter_load;
    logic          wr_fire;
    logic          wr_ok;
    logic          rd_fire;
    logic          rd_bad;
    logic [AW-1:0] base;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (load_en)  state_next = LOAD;
            LOAD:    if (!load_en) state_next = READY;
            READY:   if (load_en)  state_next = LOAD;
            default: state_next = EMPTY;
        endcase
    end

    assign busy       = (state == LOAD);
    assign enter_load = (state != LOAD) && load_en;
    // A byte arriving as load_en falls is dropped
    assign wr_fire    = (state == LOAD) && load_en && load_valid;
    assign wr_ok      = (load_count < DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count    <= '0;
            load_overflow <= 1'b0;
        end else if (enter_load) begin
            load_count    <= '0;
            load_overflow <= 1'b0;
        end else if (wr_fire) begin
            if (wr_ok) load_count    <= load_count + 32'd1;
            else       load_overflow <= 1'b1;
        end
    end

    // Contents survive reset so a partial program remains visible
    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok) mem[load_count[AW-1:0]] <= load_byte;
    end

    assign rd_fire = rd_req && (state != LOAD);
    assign rd_bad  = (rd_addr[1:0] != 2'b00) || (rd_addr > MAX_ADDR);
    assign base    = rd_addr[AW-1:0];

    always_comb begin
        b0      = mem[base];
        b1      = mem[base + AW'(1)];
        b2      = mem[base + AW'(2)];
        b3      = mem[base + AW'(3)];
        rd_word = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_err  <= rd_bad;
                rd_data <= rd_bad ? 32'd0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed + randomized bench for instr_mem_loadable, one big-endian
// and one little-endian instance driven in parallel.
module tb_instr_mem_loadable;

    localparam int D = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        rd_req;
    logic [31:0] rd_addr;

    logic [31:0] b_count, l_count;
    logic        b_ovf, l_ovf;
    logic        b_busy, l_busy;
    logic        b_valid, l_valid;
    logic [31:0] b_data, l_data;
    logic        b_err, l_err;

    int npass  = 0;
    int ntotal = 0;

    logic [7:0] mm [D];
    bit         known [D];
    int         m_count;
    bit         m_ovf;

    instr_mem_loadable #(.DEPTH_BYTES(D), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
        .load_count(b_count), .load_overflow(b_ovf), .busy(b_busy),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(b_valid), .rd_data(b_data), .rd_err(b_err)
    );

    instr_mem_loadable #(.DEPTH_BYTES(D), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
        .load_count(l_count), .load_overflow(l_ovf), .busy(l_busy),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(l_valid), .rd_data(l_data), .rd_err(l_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_err(input logic [31:0] a);
        return (a % 4 != 0) || (a > 32'(D - 4));
    endfunction

    function automatic bit all_known(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (!known[a + i]) return 0;
        return 1;
    endfunction

    // Word value from the byte model; be selects which byte lands on top
    function automatic logic [31:0] exp_word(input logic [31:0] a, input bit be);
        logic [31:0] w = 0;
        if (exp_err(a)) return 0;
        for (int i = 0; i < 4; i++) begin
            if (be) w = w + (32'(mm[a + i]) << (8 * (3 - i)));
            else    w = w + (32'(mm[a + i]) << (8 * i));
        end
        return w;
    endfunction

    task automatic check_resp(input string tag, input logic [31:0] a);
        chk({tag, "_valid_be"}, 32'(b_valid), 32'd1);
        chk({tag, "_valid_le"}, 32'(l_valid), 32'd1);
        chk({tag, "_err_be"}, 32'(b_err), 32'(exp_err(a)));
        chk({tag, "_err_le"}, 32'(l_err), 32'(exp_err(a)));
        if (exp_err(a) || all_known(a)) begin
            chk({tag, "_data_be"}, b_data, exp_word(a, 1));
            chk({tag, "_data_le"}, l_data, exp_word(a, 0));
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check_resp(tag, a);
    endtask

    task automatic load_start();
        load_en    = 1'b1;
        load_valid = 1'b0;
        tick();
        m_count = 0;
        m_ovf   = 0;
        chk("enter_busy", 32'(b_busy), 32'd1);
        chk("enter_count", b_count, 32'd0);
        chk("enter_ovf", 32'(b_ovf), 32'd0);
    endtask

    task automatic push(input logic [7:0] b, input bit watch_rd);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
        if (m_count < D) begin
            mm[m_count]    = b;
            known[m_count] = 1;
            m_count++;
        end else begin
            m_ovf = 1;
        end
        chk("push_count", b_count, 32'(m_count));
        chk("push_ovf", 32'(b_ovf), 32'(m_ovf));
        if (watch_rd) chk("load_rd_valid", 32'(b_valid | l_valid), 32'd0);
    endtask

    task automatic load_end();
        load_en    = 1'b0;
        load_valid = 1'b0;
        tick();
        chk("exit_busy", 32'(b_busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, b_count | l_count, 32'd0);
        chk({tag, "_ovf"}, 32'(b_ovf | l_ovf), 32'd0);
        chk({tag, "_busy"}, 32'(b_busy | l_busy), 32'd0);
        chk({tag, "_valid"}, 32'(b_valid | l_valid), 32'd0);
        chk({tag, "_data"}, b_data | l_data, 32'd0);
        chk({tag, "_err"}, 32'(b_err | l_err), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return 32'($urandom_range(0, D + 8));
        return 32'($urandom_range(0, D / 4 - 1) * 4);
    endfunction

    initial begin
        logic [7:0]  prog [8];
        logic [7:0]  fifth;
        logic [31:0] a;
        logic [31:0] held;

        prog = '{8'h01, 8'hCA, 8'hB0, 8'h20, 8'h01, 8'hCA, 8'hB0, 8'h22};
        for (int i = 0; i < D; i++) known[i] = 0;

        reset = 1'b1; load_en = 1'b0; load_valid = 1'b0;
        load_byte = '0; rd_req = 1'b0; rd_addr = '0;
        #1;
        chk_all_zero("por");
        tick();
        reset = 1'b0;
        tick();
        chk_all_zero("idle");

        // Test-plan program, then back-to-back fetch of 0 and 4
        load_start();
        for (int i = 0; i < 8; i++) push(prog[i], 0);
        load_end();
        chk("prog_count", b_count, 32'd8);
        rd_req  = 1'b1;
        rd_addr = 32'd0;
        tick();
        chk("tp_w0_be", b_data, 32'h01CAB020);
        chk("tp_w0_le", l_data, 32'h20B0CA01);
        check_resp("w0", 32'd0);
        rd_addr = 32'd4;
        tick();
        rd_req = 1'b0;
        chk("tp_w1_be", b_data, 32'h01CAB022);
        check_resp("w1", 32'd4);
        held = b_data;
        tick();
        chk("hold_valid", 32'(b_valid), 32'd0);
        chk("hold_data", b_data, held);

        // Stray load_valid outside LOAD is ignored
        load_valid = 1'b1;
        load_byte  = 8'h5A;
        tick();
        load_valid = 1'b0;
        chk("stray_count", b_count, 32'd8);
        fetch("stray_w0", 32'd0);

        fetch("r124", 32'd124);
        fetch("r128", 32'd128);
        fetch("rfffc", 32'hFFFF_FFFC);
        fetch("r2", 32'd2);

        // Overflow load with a fetch held pending the whole time
        load_start();
        rd_req  = 1'b1;
        rd_addr = 32'd0;
        for (int i = 0; i < D + 2; i++) push(8'($urandom), 1);
        load_end();
        chk("ovf_rd_valid", 32'(b_valid), 32'd0);
        rd_req = 1'b0;
        chk("ovf_count", b_count, 32'(D));
        chk("ovf_flag", 32'(b_ovf), 32'd1);

        // Random back-to-back fetches against the byte model
        rd_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = rand_addr();
            rd_addr = a;
            tick();
            check_resp("rnd", a);
        end
        rd_req = 1'b0;

        // Served fetch coincides with load_en rising in READY
        rd_req  = 1'b1;
        rd_addr = 32'd8;
        load_en = 1'b1;
        tick();
        rd_req = 1'b0;
        check_resp("edge_fetch", 32'd8);
        chk("edge_busy", 32'(b_busy), 32'd1);
        m_count = 0;
        m_ovf   = 0;

        // Reset after five bytes, then reload four
        for (int i = 0; i < 5; i++) push(8'($urandom), 1);
        fifth = mm[4];
        reset   = 1'b1;
        load_en = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        reset = 1'b0;
        tick();
        load_start();
        push(8'hAA, 0);
        push(8'hBB, 0);
        push(8'hCC, 0);
        push(8'hDD, 0);
        load_end();
        fetch("rl_w0", 32'd0);
        chk("rl_w0_be", b_data, 32'hAABBCCDD);
        fetch("rl_w4", 32'd4);
        chk("rl_w4_top", 32'(b_data[31:24]), 32'(fifth));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
